// File: rtl/inst_fetch_queue_pkg.sv
// Shared front-end defines: instruction bundle layout, boolean constants and
// the default fetch-queue depth.
package inst_fetch_queue_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int IFQ_DEFAULT_DEPTH = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
    logic        isJ;
    logic        isBr;
    logic        jBadAddr;
    logic        predTaken;
    logic [31:0] predAddr;
    logic [7:0]  nlpInfo;
    logic [15:0] bpdInfo;
  } InstBundle;

  function automatic logic is_ctrl(input InstBundle b);
    return b.isJ | b.isBr;
  endfunction

endpackage

// File: rtl/inst_fetch_queue_issue_select.sv
// ifq_issue_select: picks 0-2 head entries to issue so that a branch/jump is
// never split from its delay slot across issue groups.
module ifq_issue_select
  import inst_fetch_queue_pkg::*;
#(
  parameter  int DEPTH = IFQ_DEFAULT_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  InstBundle        head0_i,
  input  InstBundle        head1_i,
  input  logic [PTR_W:0]   count_i,
  output logic [1:0]       issue_o
);

  localparam logic [PTR_W:0] CNT_ZERO = '0;
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);

  // Only the control flags matter here; the remaining fields pass through the top.
  logic unused_fields;
  assign unused_fields = ^{head0_i, head1_i};

  always_comb begin
    // NOTE: default first so every path assigns issue_o and no latch is inferred.
    issue_o = 2'b00;
    if (count_i != CNT_ZERO) begin
      if (is_ctrl(head0_i)) begin
        if (count_i != CNT_ONE) issue_o = 2'b11;
      end else if (count_i == CNT_ONE || is_ctrl(head1_i)) begin
        issue_o = 2'b01;
      end else begin
        issue_o = 2'b11;
      end
    end
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Decoupling FIFO between IF_3 and decode: compacting 2-wide enqueue, 2-wide
// in-order issue. Optional statistics counters with `define IFQ_STAT_EN.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter  int DEPTH = IFQ_DEFAULT_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  InstBundle      in_inst0,
  input  InstBundle      in_inst1,
  output logic           in_ready,
  output logic           pause_req,
  input  logic           out_ready,
  output InstBundle      out_inst0,
  output InstBundle      out_inst1,
  output logic [PTR_W:0] count
`ifdef IFQ_STAT_EN
  ,
  output logic [31:0]    stall_cycles,
  output logic [31:0]    ds_hold_cycles
`endif
);

  localparam logic [PTR_W:0] FILL_LIM = (PTR_W+1)'(DEPTH - 2);

  InstBundle        mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W-1:0] head1_ptr, tail1_ptr, wr1_ptr;
  logic [PTR_W:0]   count_q, count_d, enq_amt, deq_amt;
  logic [1:0]       issue, n_enq, n_deq;
  logic             enq_en, deq_en;

  assign head1_ptr = head_q + 1'b1;
  assign tail1_ptr = tail_q + 1'b1;
  assign wr1_ptr   = in_inst0.valid ? tail1_ptr : tail_q;

  assign in_ready  = (count_q <= FILL_LIM);
  assign pause_req = ~in_ready;
  assign count     = count_q;

  ifq_issue_select #(.DEPTH(DEPTH)) u_issue_select (
    .head0_i (mem_q[head_q]),
    .head1_i (mem_q[head1_ptr]),
    .count_i (count_q),
    .issue_o (issue)
  );

  assign out_inst0 = issue[0] ? mem_q[head_q]    : '0;
  assign out_inst1 = issue[1] ? mem_q[head1_ptr] : '0;

  always_comb begin
    enq_en  = in_ready && !flush;
    deq_en  = out_ready && !flush;
    n_enq   = {1'b0, in_inst0.valid} + {1'b0, in_inst1.valid};
    n_deq   = {1'b0, issue[0]} + {1'b0, issue[1]};
    enq_amt = enq_en ? {{(PTR_W-1){1'b0}}, n_enq} : '0;
    deq_amt = deq_en ? {{(PTR_W-1){1'b0}}, n_deq} : '0;
    head_d  = head_q + deq_amt[PTR_W-1:0];
    tail_d  = tail_q + enq_amt[PTR_W-1:0];
    count_d = count_q + enq_amt - deq_amt;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: non-blocking assignments for all sequential state.
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (enq_en) begin
      if (in_inst0.valid) mem_q[tail_q]  <= in_inst0;
      if (in_inst1.valid) mem_q[wr1_ptr] <= in_inst1;
    end
  end

`ifdef IFQ_STAT_EN
  logic [31:0] stall_q, ds_hold_q;
  logic        ds_hold;

  // Delay-slot hold: entries present but the selector refuses to issue any.
  assign ds_hold = (count_q != '0) && (issue == 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q   <= '0;
      ds_hold_q <= '0;
    end else begin
      if (!in_ready && stall_q != '1)  stall_q   <= stall_q + 32'd1;
      if (ds_hold && ds_hold_q != '1)  ds_hold_q <= ds_hold_q + 32'd1;
    end
  end

  assign stall_cycles   = stall_q;
  assign ds_hold_cycles = ds_hold_q;
`endif

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Decoupling FIFO between IF_3 and decode.
- Each cycle it accepts the 0–2 instruction bundles IF_3 produces (with predecode and prediction fields) and compacts away invalid slots.
- Each cycle it issues 0–2 instructions in program order to decode.
- It never separates a branch/jump from its delay slot across issue groups, and it generates fetch backpressure.

Parameters:
- DEPTH, 16, number of entries; must be a power of two, >= 4.
- PTR_W, $clog2(DEPTH), pointer width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  pipeline flush (ctrl); empties the queue
- in_inst0  in  InstBundle  IF_3 slot 0; the .valid field marks presence
- in_inst1  in  InstBundle  IF_3 slot 1; the .valid field marks presence
- in_ready  out  1  at least 2 free entries; IF stages stall when low
- pause_req  out  1  equals ~in_ready; drives the fetch pauseReq
- out_ready  in  1  decode accepts this cycle's issue group
- out_inst0  out  InstBundle  oldest issued instruction; .valid marks presence
- out_inst1  out  InstBundle  second issued instruction; .valid marks presence
- count  out  PTR_W+1  number of occupied entries

Behaviour:
- Storage and pointers:
  - Circular array of InstBundle, with head/tail pointers of PTR_W bits.
  - Pointers wrap modulo DEPTH. count is a registered value, range 0..DEPTH.
- Reset (rst=1 at a clock edge): head=tail=0 and count=0. Consequently in_ready=1, pause_req=0, and out_inst0.valid = out_inst1.valid = 0. Array contents are don't-care.
- Enqueue:
  - Occurs when in_ready && !flush.
  - nEnq = in_inst0.valid + in_inst1.valid.
  - Valid slots are written in order at tail and tail+1, with compaction: if only in_inst1 is valid, it goes to tail.
  - Bundles are stored unmodified.
  - in_ready = (DEPTH - count) >= 2, computed from registered count only. Same-cycle dequeue does not raise it.
  - If in_ready=0, inputs are ignored; IF holds them via pause.
- Issue selection (combinational from head, head+1, and count):
  - count==0: issue nothing.
  - head0 is control (isJ|isBr) and count==1: issue nothing; wait for the delay slot.
  - head0 is control and count>=2: issue head0 + head1.
  - head0 is non-control and count>=2 and head1 is control: issue head0 only.
  - head0 is non-control and count==1: issue head0 only.
  - Otherwise (count>=2, neither control): issue head0 + head1.
  - Non-issued output slots carry .valid=0 and all other fields 0.
- Dequeue:
  - Occurs when out_ready && !flush.
  - nDeq = number of valid outputs; head advances by nDeq.
- Count update: count <= count + nEnq - nDeq when enqueue and dequeue happen simultaneously. A write and a read of the same entry in one cycle cannot occur, because issue reads only registered entries.
- Latency: an entry enqueued at edge N is visible on the outputs from cycle N+1.
- Flush: at the edge with flush=1, head=tail=count=0. Enqueue and dequeue are suppressed that cycle. Outputs in the flush cycle are still driven from the current state, but decode must ignore them.
- Boundaries:
  - Full (count==DEPTH): in_ready=0.
  - count==DEPTH-1: in_ready=0, even when a single input is valid.
  - Wrap: tail+1 wraps to 0 when tail = DEPTH-1.
  - A control instruction at the last occupied slot with no delay slot is held indefinitely until its delay slot arrives or a flush occurs.
  - rst takes priority over flush.

Optional Feature:
- IFQ_STAT_EN:
  - When defined: adds output ports stall_cycles [31:0] and ds_hold_cycles [31:0], both saturating counters cleared by rst.
    - stall_cycles increments each cycle in_ready=0.
    - ds_hold_cycles increments each cycle the delay-slot hold rule forces an empty issue while count>0.
  - When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- InstBundle (pc, inst, valid, isJ, isBr, jBadAddr, predTaken, predAddr, nlpInfo, bpdInfo) and the TRUE/FALSE constants stay in the shared defines package.
- IFQ_DEFAULT_DEPTH is added to that package.
- One sub-module is natural: ifq_issue_select, which is purely combinational and implements the issue-selection rules above (inputs: head0, head1, count; outputs: the issue mask).

Test Plan:
- Reset then 3 cycles of two valid non-control inputs with out_ready=0 → count=6; then out_ready=1 → pairs issued in PC order 0x1000, 0x1004, …; count reaches 0 after 3 cycles.
- in_inst0.valid=0 and in_inst1.valid=1 with pc=0xBFC00004 → stored at tail; next cycle out_inst0.pc=0xBFC00004 and out_inst1.valid=0.
- Enqueue a lone branch at 0x2000 (isBr=1), count=1 → no issue for 4 cycles. Then enqueue its delay slot 0x2004 → next cycle out_inst0=0x2000 and out_inst1=0x2004, both valid.
- Queue holds 0x3000 (ALU) and 0x3004 (isJ) → only 0x3000 issues. Following cycle, with 0x3008 present, 0x3004 and 0x3008 issue together.
- Fill to count=15 with DEPTH=16 → in_ready=0, pause_req=1, and inputs are ignored. Keep pushing through wrap-around for 40 cycles with out_ready toggling → no loss or duplication; the order checker passes.
- With count=9, assert flush together with a valid enqueue and out_ready=1 → next cycle count=0, outputs invalid, in_ready=1, and the dropped inputs never appear on the outputs.
